// File: rtl/bit_edge_monitor.sv
// bit_edge_monitor: counts rising and falling edges of a registered single-bit
// input over back-to-back windows of WIN_LEN cycles. Each window's counts are
// offered through a one-entry result register.
//
// Handshake: cnt_valid=1 means rise_cnt/fall_cnt/ovf hold an unconsumed
// result. These outputs stay stable until a cycle with cnt_valid & cnt_ready,
// which is the transfer. A window can finish while the register is full and
// is not being drained in that cycle. Such a window is discarded, and drop
// pulses for one cycle.
module bit_edge_monitor #(
    parameter int WIN_LEN = 100,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    input  logic             cnt_ready,
    output logic             cnt_valid,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic             ovf,
    output logic             drop
);

    localparam int               WIN_W    = $clog2(WIN_LEN);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Internal reset: asserts asynchronously, releases synchronously.
    logic [1:0] rst_sync_q;
    logic       rst_int;

    // Window bookkeeping.
    logic             prev;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_cnt_next;
    logic [CNT_W-1:0] rise_acc;
    logic [CNT_W-1:0] rise_acc_next;
    logic [CNT_W-1:0] fall_acc;
    logic [CNT_W-1:0] fall_acc_next;
    logic             ovf_acc;
    logic             ovf_acc_next;

    // Per-cycle edge evaluation.
    logic             edge_rise;
    logic             edge_fall;
    logic             counting;
    logic             win_end;
    logic             rise_hit;
    logic             fall_hit;
    logic [CNT_W-1:0] rise_sum;
    logic [CNT_W-1:0] fall_sum;
    logic             ovf_sum;

    // Result register control.
    logic load;
    logic xfer;
    logic drop_next;

    // Two-flop reset synchronizer: cleared at once by rst, released two edges later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int = rst_sync_q[1];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: en alone decides between idling and running windows.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en)  state_next = RUN;
            RUN:     if (!en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Edge detection and saturating sums, including this cycle's edge.
    always_comb begin
        edge_rise = din & ~prev;
        edge_fall = ~din & prev;
        counting  = (state == RUN) && en;
        win_end   = counting && (win_cnt == WIN_LAST);
        rise_hit  = edge_rise && (rise_acc == CNT_MAX);
        fall_hit  = edge_fall && (fall_acc == CNT_MAX);
        rise_sum  = (edge_rise && !rise_hit) ? rise_acc + CNT_W'(1) : rise_acc;
        fall_sum  = (edge_fall && !fall_hit) ? fall_acc + CNT_W'(1) : fall_acc;
        ovf_sum   = ovf_acc | rise_hit | fall_hit;
    end

    // Accumulators advance only while counting. Idle, abort and window end all restart them at zero.
    always_comb begin
        win_cnt_next  = '0;
        rise_acc_next = '0;
        fall_acc_next = '0;
        ovf_acc_next  = 1'b0;
        if (counting && !win_end) begin
            win_cnt_next  = win_cnt + WIN_W'(1);
            rise_acc_next = rise_sum;
            fall_acc_next = fall_sum;
            ovf_acc_next  = ovf_sum;
        end
    end

    // Result register decisions: load when empty or draining, otherwise discard.
    always_comb begin
        xfer      = cnt_valid & cnt_ready;
        load      = win_end & (~cnt_valid | cnt_ready);
        drop_next = win_end & cnt_valid & ~cnt_ready;
    end

    // Window state registers. prev follows din in every state, so entering RUN never sees a false edge.
    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            prev     <= 1'b0;
            win_cnt  <= '0;
            rise_acc <= '0;
            fall_acc <= '0;
            ovf_acc  <= 1'b0;
        end else begin
            prev     <= din;
            win_cnt  <= win_cnt_next;
            rise_acc <= rise_acc_next;
            fall_acc <= fall_acc_next;
            ovf_acc  <= ovf_acc_next;
        end
    end

    // Output register: a new load wins over a simultaneous transfer. Otherwise a transfer empties the register.
    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            cnt_valid <= 1'b0;
            rise_cnt  <= '0;
            fall_cnt  <= '0;
            ovf       <= 1'b0;
            drop      <= 1'b0;
        end else begin
            drop <= drop_next;
            if (load) begin
                cnt_valid <= 1'b1;
                rise_cnt  <= rise_sum;
                fall_cnt  <= fall_sum;
                ovf       <= ovf_sum;
            end else if (xfer) begin
                cnt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/bit_edge_monitor.md
# bit_edge_monitor

Downstream consumer of the single-bit registered output from the input-conditioning stage. Samples that bit on every `clk`, detects rising and falling edges, and counts them over fixed windows of `WIN_LEN` cycles. At the end of each window it presents the two counts, plus a saturation flag, through a one-entry valid/ready output register.

## Interface
Parameters:
- `WIN_LEN`, 100: window length in clk cycles; must be ≥2.
- `CNT_W`, 8: width of each edge counter.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `din`, in, 1: monitored bit; synchronous to `clk`, driven by the upstream register.
- `en`, in, 1: 1 runs windows; 0 idles and discards the partial window.
- `cnt_ready`, in, 1: consumer accepts the result.
- `cnt_valid`, out, 1: result register holds an unconsumed result.
- `rise_cnt`, out, CNT_W: rising edges in the reported window.
- `fall_cnt`, out, CNT_W: falling edges in the reported window.
- `ovf`, out, 1: at least one counter saturated in the reported window.
- `drop`, out, 1: one-cycle pulse when a finished window is discarded because of backpressure.

## Operation
- **Reset:**
  - `rst` low asynchronously clears all state.
  - Internally, `rst` passes through a 2-flop synchronizer. Assertion is asynchronous; deassertion is synchronous.
  - Logic leaves reset on the 2nd rising `clk` edge after `rst` goes high.
- **Reset values:** `cnt_valid`=0, `rise_cnt`=0, `fall_cnt`=0, `ovf`=0, `drop`=0. Internal state: FSM=IDLE, `prev`=0.
- **FSM:**
  - IDLE: `prev` tracks `din` every cycle. Window counter and edge counters are held at 0. Moves to RUN when `en`=1.
  - RUN: counts edges. Moves to IDLE when `en`=0, discarding all partial counts. No result is produced and `drop` is not asserted.
- **Edge detection:**
  - Rise is `din`=1 & `prev`=0. Fall is `din`=0 & `prev`=1.
  - `prev`<=`din` every cycle.
  - Because `prev` tracks `din` in IDLE, entering RUN never produces a false edge.
- **Window:**
  - The window counter runs 0..WIN_LEN-1 in RUN.
  - In the cycle where it reads WIN_LEN-1, that cycle's edge is included and the window ends.
  - At window end the final counts are offered to the result register. Window and edge counters restart at 0, so windows run back-to-back with no gap.
- **Saturation:**
  - Each counter stops at 2^CNT_W-1.
  - Any increment attempted at max sets the per-window overflow flag. The flag is cleared at window start.
- **Result register (window end):**
  - Empty (`cnt_valid`=0), or being consumed this cycle (`cnt_valid`&`cnt_ready`): load counts and `ovf`; `cnt_valid`<=1.
  - Full and not consumed: keep the old contents and pulse `drop` for one cycle.
- **Handshake:**
  - Transfer happens on a cycle where `cnt_valid`&`cnt_ready`.
  - Without a simultaneous window-end load, `cnt_valid`<=0.
  - Outputs are stable while `cnt_valid`=1 and `cnt_ready`=0.
- **Re-enable:** `en` 0→1 always starts a fresh window at count 0. A pending result is unaffected by `en`.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- An edge on `din`, presented before clk edge t, is counted at edge t.
- Result latency: `cnt_valid` and the data are visible right after the clk edge that samples the window's last cycle. Window k ends WIN_LEN cycles after window k-1 ends.
- `drop` is high for exactly the one cycle following the discarding edge.
- After `en` 1→0, no counting happens from the next edge onward.
- `rst` asserted mid-window or with a pending result clears everything immediately, including `cnt_valid`.

## Test plan
1. **Reset:**
   - Stimulus: hold `rst`=0 with `din`/`en` toggling, then release.
   - Required: all outputs 0 throughout. No counting before the 2nd clk edge after release.
2. **Basic window** (WIN_LEN=10, CNT_W=4, `cnt_ready`=1):
   - Stimulus: `din` 0→1 at cycles 1, 4, 7; 1→0 at cycles 2, 5.
   - Required: `rise_cnt`=3, `fall_cnt`=2, `ovf`=0, `cnt_valid` high for exactly 1 cycle.
3. **Saturation** (WIN_LEN=10, CNT_W=2):
   - Stimulus: `din` toggles every cycle from 0.
   - Required: `rise_cnt`=3, `fall_cnt`=3, `ovf`=1. The next window with constant `din` reports 0, 0, `ovf`=0.
4. **Backpressure:**
   - Stimulus: `cnt_ready`=0 across two window ends.
   - Required: the first result is held unchanged, with `drop` pulsing 1 cycle at the 2nd window end. Then `cnt_ready`=1 for one cycle gives `cnt_valid`=0 on the next cycle.
5. **Simultaneous:**
   - Stimulus: `cnt_ready`=1 exactly in the window-end cycle while `cnt_valid`=1.
   - Required: the new counts load, `cnt_valid` stays 1, `drop`=0.
6. **Enable abort:**
   - Stimulus: `en`=0 at window cycle 5 after 2 edges, with `din`=1 held in IDLE; then `en`=1 with `din`=1 constant.
   - Required: no result from the aborted window. The next result is `rise_cnt`=0, `fall_cnt`=0, with no spurious edge.
